// File: rtl/int_ctrl_if.sv
// Program-counter side handshake of the interrupt controller.
// The controller raises int_occurred/int_vec; the pipeline answers with
// its stall and the RTI-in-EX indication that ends an interrupt service.
interface int_ctrl_if;
   logic        int_occurred;
   logic [15:0] int_vec;
   logic        stall_IM_ID;
   logic        rti_ID_EX;

   // Controller side.
   modport master (
      output int_occurred,
      output int_vec,
      input  stall_IM_ID,
      input  rti_ID_EX
   );

   // Pipeline / PC-stage side.
   modport slave (
      input  int_occurred,
      input  int_vec,
      output stall_IM_ID,
      output rti_ID_EX
   );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller feeding the PC stage.
// Latches requests into a pending register, masks them per source, gates
// them with a global enable and raises one request at a time.  Source 0 is
// the highest priority.  Nested interrupts are not supported: once a request
// is accepted, nothing new is raised until the RTI reaches EX.
//
// Build option: define INT_CTRL_EDGE_EN for edge-triggered requests
// (pending sets on a rising irq edge, clears on acceptance).  Without it the
// controller is level-sensitive and pending simply follows irq one cycle late.
module int_ctrl #(
   parameter int          NUM_IRQ  = 4,
   parameter logic [15:0] VEC_BASE = 16'h0010
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               int_en,
   input  logic               mask_wr,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   int_ctrl_if.master         pc,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] in_service
);

   localparam int                 IDX_W    = 3;
   localparam logic [NUM_IRQ-1:0] ONE_HOT0 = NUM_IRQ'(1'b1);
   localparam logic [NUM_IRQ-1:0] ALL_ZERO = {NUM_IRQ{1'b0}};
   localparam logic [NUM_IRQ-1:0] ALL_ONE  = {NUM_IRQ{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   // Lowest set index of v; MSB of the result flags that any bit was set.
   function automatic logic [IDX_W:0] lowest_set(input logic [NUM_IRQ-1:0] v);
      logic [IDX_W:0] r;
      r = {1'b0, {IDX_W{1'b0}}};
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = {1'b1, IDX_W'(i)};
         end
      end
      return r;
   endfunction

   state_t             state_r;
   logic [NUM_IRQ-1:0] pending_r;
   logic [NUM_IRQ-1:0] mask_r;
   logic [NUM_IRQ-1:0] sel_r;
   logic [NUM_IRQ-1:0] in_service_r;
   logic               int_occurred_r;
   logic [15:0]        int_vec_r;

   logic [NUM_IRQ-1:0] eligible_s;
   logic [IDX_W:0]     pick_s;
   logic               any_s;
   logic [IDX_W-1:0]   idx_s;
   logic               accept_s;

   // Priority selection among unmasked pending sources, and acceptance detect.
   always_comb begin
      eligible_s = pending_r & ~mask_r;
      pick_s     = lowest_set(eligible_s);
      any_s      = pick_s[IDX_W];
      idx_s      = pick_s[IDX_W-1:0];
      if ((state_r == ST_REQ) && !pc.stall_IM_ID) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

`ifdef INT_CTRL_EDGE_EN
   logic [NUM_IRQ-1:0] irq_q_r;
   logic [NUM_IRQ-1:0] clr_s;

   // Bit to drop from pending: the committed source, on its acceptance edge.
   always_comb begin
      if (accept_s) begin
         clr_s = sel_r;
      end else begin
         clr_s = ALL_ZERO;
      end
   end

   // Edge capture: a new rising edge wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q_r   <= ALL_ZERO;
         pending_r <= ALL_ZERO;
      end else begin
         irq_q_r   <= irq;
         pending_r <= (pending_r & ~clr_s) | (irq & ~irq_q_r);
      end
   end
`else
   // Level capture: pending mirrors the request lines one cycle late.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r <= ALL_ZERO;
      end else begin
         pending_r <= irq;
      end
   end
`endif

   // Mask register; every source starts out masked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_r <= ALL_ONE;
      end else if (mask_wr) begin
         mask_r <= mask_wdata;
      end
   end

   // Request/service sequencer; a raised request is frozen until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         sel_r          <= ALL_ZERO;
         int_occurred_r <= 1'b0;
         int_vec_r      <= 16'h0000;
         in_service_r   <= ALL_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (int_en && any_s) begin
                  state_r        <= ST_REQ;
                  sel_r          <= ONE_HOT0 << idx_s;
                  int_occurred_r <= 1'b1;
                  int_vec_r      <= VEC_BASE + 16'(idx_s);
               end
            end
            ST_REQ: begin
               if (accept_s) begin
                  state_r        <= ST_SERVICE;
                  int_occurred_r <= 1'b0;
                  in_service_r   <= sel_r;
               end
            end
            ST_SERVICE: begin
               if (pc.rti_ID_EX) begin
                  state_r      <= ST_IDLE;
                  in_service_r <= ALL_ZERO;
               end
            end
            default: begin
               state_r        <= ST_IDLE;
               int_occurred_r <= 1'b0;
               in_service_r   <= ALL_ZERO;
            end
         endcase
      end
   end

   assign pc.int_occurred = int_occurred_r;
   assign pc.int_vec      = int_vec_r;
   assign pending         = pending_r;
   assign in_service      = in_service_r;

endmodule
